// File: rtl/hall_if.sv
// Hall front-end signal bundle between sensor conditioning and its consumer.
// HALL_POS_COUNT_EN adds the signed position counter output.
interface hall_if;
    logic [2:0] h_raw;
    logic       fault_clr;
    logic [2:0] h_clean;
    logic [2:0] sector;
    logic       h_edge;
    logic       dir;
    logic       h_fault;
`ifdef HALL_POS_COUNT_EN
    logic [15:0] pos_cnt;

    modport master (
        output h_raw, fault_clr,
        input  h_clean, sector, h_edge, dir, h_fault, pos_cnt
    );
    modport slave (
        input  h_raw, fault_clr,
        output h_clean, sector, h_edge, dir, h_fault, pos_cnt
    );
`else
    modport master (
        output h_raw, fault_clr,
        input  h_clean, sector, h_edge, dir, h_fault
    );
    modport slave (
        input  h_raw, fault_clr,
        output h_clean, sector, h_edge, dir, h_fault
    );
`endif
endinterface

// File: rtl/hall_input_conditioner.sv
// Hall input synchroniser, debouncer and 6-step sequence validator.
// HALL_POS_COUNT_EN adds a wrapping 16-bit up/down position counter.
module hall_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8
) (
    input logic clk,
    input logic rst,
    hall_if.slave bus
);
    typedef enum logic {ACQ, TRACK} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_STB = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       sync_q [SYNC_STAGES];
    logic [2:0]       synced;
    logic [2:0]       cand_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stable;

    state_t     state_q, state_d;
    logic [2:0] clean_q, clean_d;
    logic [2:0] sector_q, sector_d;
    logic       edge_q, edge_d;
    logic       dir_q, dir_d;
    logic       fault_q, fault_d;

    logic [2:0] code_sec;
    logic [3:0] step_raw;
    logic [3:0] step;

    function automatic logic [2:0] sector_of(input logic [2:0] code);
        case (code)
            3'b001:  return 3'd1;
            3'b011:  return 3'd2;
            3'b010:  return 3'd3;
            3'b110:  return 3'd4;
            3'b100:  return 3'd5;
            3'b101:  return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 3'b000;
        end else begin
            sync_q[0] <= bus.h_raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Counter saturates past the stable value so each candidate fires once.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_q <= 3'b000;
            cnt_q  <= '0;
        end else if (synced != cand_q) begin
            cand_q <= synced;
            cnt_q  <= '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stable   = (cnt_q == CNT_STB);
    assign code_sec = sector_of(cand_q);
    assign step_raw = {1'b0, code_sec} + 4'd6 - {1'b0, sector_q};
    assign step     = (step_raw >= 4'd6) ? step_raw - 4'd6 : step_raw;

    always_comb begin
        state_d  = state_q;
        clean_d  = clean_q;
        sector_d = sector_q;
        edge_d   = 1'b0;
        dir_d    = dir_q;
        fault_d  = fault_q;
        if (bus.fault_clr && state_q == TRACK) fault_d = 1'b0;
        if (stable) begin
            unique case (state_q)
                ACQ: begin
                    if (code_sec == 3'd0) begin
                        fault_d = 1'b1;
                    end else begin
                        clean_d  = cand_q;
                        sector_d = code_sec;
                        state_d  = TRACK;
                    end
                end
                TRACK: begin
                    if (code_sec == 3'd0) begin
                        fault_d  = 1'b1;
                        sector_d = 3'd0;
                        state_d  = ACQ;
                    end else if (step != 4'd0) begin
                        clean_d  = cand_q;
                        sector_d = code_sec;
                        if (step == 4'd1) begin
                            edge_d = 1'b1;
                            dir_d  = 1'b1;
                        end else if (step == 4'd5) begin
                            edge_d = 1'b1;
                            dir_d  = 1'b0;
                        end else begin
                            fault_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACQ;
            clean_q  <= 3'b000;
            sector_q <= 3'd0;
            edge_q   <= 1'b0;
            dir_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            clean_q  <= clean_d;
            sector_q <= sector_d;
            edge_q   <= edge_d;
            dir_q    <= dir_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.h_clean = clean_q;
    assign bus.sector  = sector_q;
    assign bus.h_edge  = edge_q;
    assign bus.dir     = dir_q;
    assign bus.h_fault = fault_q;

`ifdef HALL_POS_COUNT_EN
    logic [15:0] pos_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q <= 16'h0000;
        end else if (edge_d) begin
            pos_q <= dir_d ? pos_q + 16'd1 : pos_q - 16'd1;
        end
    end

    assign bus.pos_cnt = pos_q;
`endif
endmodule
